// File: rtl/rca_pkg.sv
// rca_pkg: shared defaults and elaboration helpers for the pipelined ripple-carry adder
package rca_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;
  function automatic int stages(input int w, input int c);
    return c > 0 ? w / c : 1;
  endfunction
  function automatic bit chunk_ok(input int w, input int c);
    return c >= 1 && c <= w && w % c == 0;
  endfunction
endpackage

// File: rtl/rca_slice.sv
// rca_slice: combinational CHUNK-bit ripple-carry slice built from full adders
module rca_slice import rca_pkg::*; #(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign cout = w_c[CHUNK];
  assign cmsb = w_c[CHUNK-1];
endmodule

// File: rtl/pipelined_rca.sv
// pipelined_rca: WIDTH-bit adder split into CHUNK-bit ripple slices, one per stage, valid/ready on both ends
module pipelined_rca import rca_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c4,
  output logic             ovf
);
  localparam int STAGES = stages(WIDTH, CHUNK);
  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad
    $error("pipelined_rca: WIDTH must be a positive multiple of CHUNK");
  end
  // Accepted operands land in an input rank first, so a result shows STAGES edges after its accept edge
  logic             r_iv, r_ic, r_m;
  logic [WIDTH-1:0] r_ia, r_ib;
  logic [STAGES-1:0] r_v, r_c, w_pv, w_pc, w_co;
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic [WIDTH-1:0] w_pa [STAGES];
  logic [WIDTH-1:0] w_pb [STAGES];
  logic [WIDTH-1:0] w_ps [STAGES];
  logic [WIDTH-1:0] w_ns [STAGES];
  logic [CHUNK-1:0] w_ss [STAGES];
  logic             w_cm [STAGES];
  logic             w_stall;
  assign w_stall   = r_v[STAGES-1] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_v[STAGES-1];
  assign s         = r_s[STAGES-1];
  assign c4        = r_c[STAGES-1];
  assign ovf       = r_c[STAGES-1] ^ r_m;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_first
      assign w_pv[k] = r_iv;
      assign w_pa[k] = r_ia;
      assign w_pb[k] = r_ib;
      assign w_pc[k] = r_ic;
      assign w_ps[k] = '0;
    end else begin : g_next
      assign w_pv[k] = r_v[k-1];
      assign w_pa[k] = r_a[k-1];
      assign w_pb[k] = r_b[k-1];
      assign w_pc[k] = r_c[k-1];
      assign w_ps[k] = r_s[k-1];
    end
    rca_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (w_pa[k][k*CHUNK +: CHUNK]),
      .b    (w_pb[k][k*CHUNK +: CHUNK]),
      .cin  (w_pc[k]),
      .s    (w_ss[k]),
      .cout (w_co[k]),
      .cmsb (w_cm[k])
    );
    // Bits above the sum computed so far are always zero, so OR-ing the new slice in is exact
    assign w_ns[k] = w_ps[k] | (WIDTH'(w_ss[k]) << (k*CHUNK));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iv <= 1'b0;
      r_ic <= 1'b0;
      r_ia <= '0;
      r_ib <= '0;
      r_v  <= '0;
      r_c  <= '0;
      r_m  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (!w_stall) begin
      r_iv <= in_valid;
      r_ic <= c0;
      r_ia <= a;
      r_ib <= b;
      r_v  <= w_pv;
      r_c  <= w_co;
      r_m  <= w_cm[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_pa[k];
        r_b[k] <= w_pb[k];
        r_s[k] <= w_ns[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: table vectors plus scoreboarded random, backpressure and reset sequences
module tb_pipelined_rca;
  localparam int LAT = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, iv, c0, ordy, irdy, ov, c4, ovf;
  logic [15:0] a, b, s;
  logic        iv8, c08, irdy8, ov8, c48, ovf8;
  logic [7:0]  a8, b8, s8;
  logic        iv12, c012, irdy12, ov12, c412, ovf12;
  logic [11:0] a12, b12, s12;
  pipelined_rca #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(irdy), .a(a), .b(b), .c0(c0),
    .out_valid(ov), .out_ready(ordy), .s(s), .c4(c4), .ovf(ovf));
  pipelined_rca #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(irdy8), .a(a8), .b(b8), .c0(c08),
    .out_valid(ov8), .out_ready(1'b1), .s(s8), .c4(c48), .ovf(ovf8));
  pipelined_rca #(.WIDTH(12), .CHUNK(3)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(irdy12), .a(a12), .b(b12), .c0(c012),
    .out_valid(ov12), .out_ready(1'b1), .s(s12), .c4(c412), .ovf(ovf12));
  typedef struct { logic [15:0] a, b; logic c0; logic [15:0] s; logic c4, ovf; } vec_t;
  typedef struct { logic [15:0] s; logic c4, ovf; int cyc, st; } exp_t;
  exp_t        q[$];
  vec_t        tbl[10];
  int          total = 0, bad = 0, cyc = 0, stalls = 0;
  logic [15:0] es, prev_s;
  logic        ec, eo, prev_stall = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    t = {1'b0, x} + {1'b0, y} + 17'(c);
    return {t[16], (x[15] == y[15]) && (t[15] != x[15]), t[15:0]};
  endfunction
  task automatic put(input logic v, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                     input logic [15:0] xs, input logic xc, input logic xo);
    iv = v; a = av; b = bv; c0 = cv; es = xs; ec = xc; eo = xo;
  endtask
  task automatic put_rand();
    logic [15:0] ra, rb;
    logic        rc;
    logic [17:0] m;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
    m = model(ra, rb, rc);
    put(1'b1, ra, rb, rc, m[15:0], m[17], m[16]);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: accepts are pushed and results popped at the negedge before the edge that transfers them
  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (rst_n === 1'b1) begin
      if (prev_stall) chk("s_hold", s, prev_s);
      if (ov && ordy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: out_valid with s=%0h and nothing outstanding", s);
        end else begin
          e = q.pop_front();
          chk("s", s, e.s);
          chk("c4", c4, e.c4);
          chk("ovf", ovf, e.ovf);
          chk("latency", cyc - e.cyc, LAT + 1 + stalls - e.st);
        end
      end
      prev_stall = ov && !ordy;
      prev_s = s;
      if (prev_stall) stalls++;
      if (iv && irdy) q.push_back('{es, ec, eo, cyc, stalls});
    end else prev_stall = 1'b0;
  end
  task automatic alt(input int w, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                     input logic [15:0] xs, input logic xc, input logic xo, input int xl);
    int n;
    if (w == 8) begin iv8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; c08 = cv; end
    else begin iv12 = 1'b1; a12 = av[11:0]; b12 = bv[11:0]; c012 = cv; end
    tick();
    iv8 = 1'b0; iv12 = 1'b0;
    n = 0;
    while (!(w == 8 ? ov8 : ov12) && n < 10) begin tick(); n++; end
    chk($sformatf("alt%0d_latency", w), n, xl);
    chk($sformatf("alt%0d_s", w), w == 8 ? {8'h0, s8} : {4'h0, s12}, xs);
    chk($sformatf("alt%0d_c4", w), w == 8 ? c48 : c412, xc);
    chk($sformatf("alt%0d_ovf", w), w == 8 ? ovf8 : ovf12, xo);
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    tbl[0] = '{16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[6] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    tbl[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    tbl[9] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    rst_n = 1'b0; ordy = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; c08 = 1'b0;
    iv12 = 1'b0; a12 = '0; b12 = '0; c012 = 1'b0;
    put(1'b1, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", ov, 1'b0);
      chk("rst_s", s, 16'h0);
      chk("rst_c4", c4, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; iv = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", irdy, 1'b1);
    tick();
    put(1'b1, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0);
    tick();
    iv = 1'b0;
    n = 0;
    while (!ov && n < 10) begin tick(); n++; end
    chk("latency16", n, LAT);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      put(1'b1, tbl[i].a, tbl[i].b, tbl[i].c0, tbl[i].s, tbl[i].c4, tbl[i].ovf);
      tick();
    end
    iv = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      put_rand();
      tick();
      iv = 1'b0;
      repeat (i % 3) tick();
    end
    repeat (8) tick();
    ordy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put_rand();
      tick();
      if (i >= 4) chk("in_ready_stall", irdy, 1'b0);
    end
    iv = 1'b0; ordy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("drain_ov", ov, 1'b1);
      tick();
    end
    repeat (4) tick();
    chk("q_empty_bp", q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      put_rand();
      tick();
    end
    rst_n = 1'b0; iv = 1'b0;
    q.delete();
    tick();
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov) n++;
      tick();
    end
    chk("no_ghost", n, 0);
    put(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    tick();
    iv = 1'b0;
    repeat (8) tick();
    chk("q_empty_rst", q.size(), 0);
    alt(8, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1);
    alt(8, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    alt(8, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 1);
    alt(12, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 4);
    alt(12, 16'h0FFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    alt(12, 16'h07FF, 16'h0001, 1'b0, 16'h0800, 1'b0, 1'b1, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add into WIDTH/CHUNK ripple-carry slices, one slice per pipeline stage, with the carry registered between stages.
- Uses a valid/ready handshake on both ends and adds signed-overflow detection.
- Sits in the datapath wherever a wide adder must close timing at high clock rates.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per pipeline stage. 1 <= CHUNK <= WIDTH.
- STAGES, WIDTH/CHUNK: derived local parameter, not overridable. Equals the pipeline depth.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  a, b and c0 are presented.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c0  in  1  carry in.
- out_valid  out  1  s, c4 and ovf hold a result.
- out_ready  in  1  downstream consumes the result this cycle.
- s  out  WIDTH  sum, (a+b+c0) mod 2^WIDTH.
- c4  out  1  carry out of the MSB. The name is kept from the 4-bit block.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low at a clk edge): clears every stage valid bit.
  - Output values after reset: out_valid=0, s=0, c4=0, ovf=0.
  - All partial-sum and carry registers are cleared.
  - in_ready=1 from the first cycle after reset.
  - A reset asserted mid-operation discards all in-flight operations. No partial result ever appears.
- Pipeline structure: stage k (k=0..STAGES-1) holds:
  - a valid bit;
  - the low (k+1)*CHUNK sum bits computed so far;
  - the registered carry;
  - the not-yet-added upper operand bits of a and b.
- Stage k adds slice [k*CHUNK +: CHUNK] of a and b plus the incoming carry.
  - The carry into stage 0 is c0.
- The final stage also registers the carry into the MSB, which is needed for ovf.
- Handshake:
  - An operation transfers in when in_valid && in_ready at a clk edge.
  - A result transfers out when out_valid && out_ready.
- Stall rule: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, every stage holds its contents, including bubbles. Bubbles are not collapsed.
- Latency: a result accepted at edge N becomes visible with out_valid=1 after edge N+STAGES when there is no stall.
  - Throughput is one operation per cycle.
  - Each stall cycle adds exactly one cycle of latency to every in-flight operation.
- Simultaneous accept and consume in the same cycle is legal and keeps full throughput.
- in_valid low inserts a bubble that travels down the pipeline with valid=0.
- Outputs are registered. s, c4 and ovf stay stable while out_valid && !out_ready.
- s, c4 and ovf values when out_valid=0 are don't-care. The implementation may hold their last values.
- Wrap-around: the sum is truncated to WIDTH bits; c4 reports the lost carry.
- CHUNK == WIDTH degenerates to a single-stage registered adder (STAGES=1, latency 1).
- Elaboration error if WIDTH % CHUNK != 0.

Decomposition:
- Shared package rca_pkg:
  - default WIDTH and CHUNK constants;
  - a function computing STAGES;
  - the elaboration-check macro or function for the divisibility rule.
- One sub-module, rca_slice: a combinational CHUNK-bit ripple-carry slice.
  - Ports: a, b, cin, s, cout, cmsb (carry into the slice MSB).
  - Built from full adders, i.e. the existing RCA generalised.
  - Instantiated STAGES times via generate.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Reset: hold rst_n=0 for 3 cycles while driving in_valid=1 -> out_valid stays 0 and s=0, c4=0, ovf=0. After release, in_ready=1.
- Latency: with out_ready=1, send a=16'h0001, b=16'h0001, c0=1 -> out_valid rises exactly 4 cycles later with s=16'h0003, c4=0, ovf=0.
- Carry ripple across stages and wrap-around:
  - a=16'hFFFF, b=16'h0001, c0=0 -> s=16'h0000, c4=1, ovf=0.
  - a=16'h7FFF, b=16'h0001, c0=0 -> s=16'h8000, c4=0, ovf=1.
- Back-to-back with bubbles: send 8 random operations with in_valid toggling -> results emerge in order, matching a reference a+b+c0 model, with the bubble spacing preserved.
- Backpressure:
  - Fill the pipe and hold out_ready=0 for 5 cycles -> in_ready=0, s held stable, no operation lost or duplicated.
  - Release out_ready -> one result per cycle.
- Reset mid-flight and alternate configurations:
  - Pulse rst_n low with 3 operations in flight -> none emerge; the next accepted operation yields the correct result.
  - Rerun the latency and wrap-around checks with WIDTH=8, CHUNK=8 (latency 1) and WIDTH=12, CHUNK=3 (latency 4).
